input_controller: RTL and testbench
===================================

Name: input_controller

Overview:
- Receive side of the byte-stream transceiver path.
- Accepts an AXI-Stream-style byte stream and packs bytes into DATA_WIDTH-bit words, MSB byte first.
- Writes each word into the frame buffer at addresses 0x00, 0x04, 0x08, 0x0C; one frame is NUM_WORDS words.
- Checks frame boundaries against tlast and reports completion or error per frame.

Parameters:
- ADDR_WIDTH, 8, width of wr_addr.
- DATA_WIDTH, 80, word width. Must be a multiple of 8. BYTES = DATA_WIDTH/8 = 10.
- NUM_WORDS, 4, words per frame.
- ADDR_STEP, 4, address increment between consecutive words.

Ports:
- clk_in  in  1  system clock, all logic on its rising edge
- rst_n_in  in  1  asynchronous active-low reset
- tdata_in  in  8  stream byte
- tvalid_in  in  1  tdata_in/tlast_in valid
- tlast_in  in  1  marks last byte of frame
- tready_out  out  1  block can accept a byte this cycle
- wr_addr  out  ADDR_WIDTH  buffer write address
- wr_data  out  DATA_WIDTH  buffer write data
- wr_en  out  1  single-cycle write strobe
- frame_done  out  1  one-cycle pulse: frame received with correct tlast
- frame_err  out  1  one-cycle pulse: framing error

Behaviour:
- Clock and reset: one clock, clk_in; reset is asynchronous and active-low, rst_n_in.
- Reset values: tready_out=1, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0. Byte counter, word counter and state are cleared, with state = RECV.
- Reset mid-frame: the partial word and the frame position are discarded. After release, the next accepted byte is byte 0 of word 0.
- Handshake: a byte is accepted on a rising edge when tvalid_in && tready_out. With tvalid_in low, all counters and the shift register hold.
- Packing:
  - Accepted byte k (0..BYTES-1) of a word goes to bits [DATA_WIDTH-1-8k -: 8].
  - Byte 0 lands in [79:72]; byte 9 lands in [7:0].
- States:
  - RECV: tready_out=1 and bytes are accepted.
    - On acceptance of byte BYTES-1 → WRITE.
    - On acceptance of an early tlast → RECV, with the error handling below.
  - WRITE: one cycle.
    - tready_out=0 and wr_en=1.
    - wr_addr = word_cnt*ADDR_STEP (truncated to ADDR_WIDTH); wr_data = the assembled word.
    - Next state is RECV, except DRAIN when the missing-tlast case below applies.
  - DRAIN: tready_out=1 and all accepted bytes are discarded with no writes. Acceptance of a byte with tlast_in=1 → RECV, counters at 0.
- Latency: the 10th byte is accepted at edge N; wr_en is high during cycle N+1 (registered outputs); the next byte can be accepted at edge N+2.
- Word counter:
  - Increments after each WRITE.
  - Wraps to 0 after word NUM_WORDS-1, i.e. wr_addr sequence 0x00, 0x04, 0x08, 0x0C, 0x00.
  - wr_addr holds its last value when wr_en=0.
- Frame checking:
  - tlast on the final byte of word NUM_WORDS-1: frame_done=1 in the same cycle as that word's wr_en.
  - tlast on any earlier byte (including the final byte of words 0..NUM_WORDS-2):
    - frame_err=1 in the next cycle and no write of the partial or completed word.
    - Byte and word counters reset to 0; previously written words of the frame stay in the buffer.
  - Final byte of word NUM_WORDS-1 accepted without tlast:
    - The word is still written; frame_err=1 together with that wr_en, and frame_done=0.
    - State → DRAIN.
- frame_done and frame_err are never high in the same cycle. Each is at most one cycle wide.

Test Plan:
- Clean frame:
  - Stimulus: bytes 0x01..0x28 with tvalid_in continuous and tlast_in on 0x28.
  - Required writes: 4 wr_en pulses.
    - addr 0x00, data 0x0102030405060708090A.
    - addr 0x04, data 0x0B0C..0x14.
    - addr 0x08, data 0x15..0x1E.
    - addr 0x0C, data 0x1F..0x28.
  - Timing and flags: each wr_en comes one cycle after its 10th byte; tready_out is low exactly in those cycles; frame_done pulses with the 4th write; frame_err=0.
- Throttled input: same frame with tvalid_in toggling pseudo-randomly (about 50% duty) → identical writes and frame_done; no byte lost or duplicated.
- Early tlast: 15 bytes 0xA0..0xAE with tlast on 0xAE → one write (addr 0x00, 0xA0..0xA9); frame_err pulse after 0xAE; a following clean frame starts at addr 0x00.
- Missing tlast: 40 bytes with no tlast, then 3 bytes with tlast on the 3rd, then a clean frame.
  - Four writes occur, and frame_err pulses with the write to 0x0C.
  - The 3 extra bytes are discarded; the clean frame writes 0x00..0x0C and gives frame_done.
- Reset mid-frame: assert rst_n_in after 23 bytes of a frame → all outputs at reset values immediately (asynchronous). After release, a clean frame writes from addr 0x00 with correct data.
- Back-to-back frames: two clean frames with no idle cycles → 8 writes with wr_addr 0x00, 0x04, 0x08, 0x0C, 0x00, 0x04, 0x08, 0x0C, and two frame_done pulses.

Source files
------------

// File: rtl/input_controller.sv
// Receive side of the byte-stream path: packs an AXI-Stream-style byte stream into
// DATA_WIDTH-bit words (MSB byte first), writes them to the frame buffer and checks tlast framing.
`timescale 1ns/1ps
module input_controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 80,
    parameter int NUM_WORDS  = 4,
    parameter int ADDR_STEP  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [7:0]            tdata_in,
    input  logic                  tvalid_in,
    input  logic                  tlast_in,
    output logic                  tready_out,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [1:0]            o_state
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Handshake: a byte transfers on a rising edge where tvalid_in && tready_out;
    // tdata_in/tlast_in are only meaningful while tvalid_in is high.
    state_t                r_state;
    logic                  r_drain;
    logic [DATA_WIDTH-9:0] r_shift;
    logic [BCW-1:0]        r_byte_cnt;
    logic [WCW-1:0]        r_word_cnt;

    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic [DATA_WIDTH-1:0] w_word;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_accept    = tvalid_in && tready_out;
    assign w_last_byte = (r_byte_cnt == BCW'(BYTES - 1));
    assign w_last_word = (r_word_cnt == WCW'(NUM_WORDS - 1));
    // The final byte is never stored: it is merged straight into the word being written.
    assign w_word      = {r_shift, tdata_in};
    assign w_addr      = ADDR_WIDTH'(r_word_cnt) * ADDR_WIDTH'(ADDR_STEP);
    assign o_state     = r_state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= RECV;
            r_drain    <= 1'b0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            tready_out <= 1'b1;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                RECV: begin
                    if (w_accept) begin
                        if (w_last_byte) begin
                            r_byte_cnt <= '0;
                            if (tlast_in && !w_last_word) begin
                                frame_err  <= 1'b1;
                                r_word_cnt <= '0;
                            end else begin
                                wr_en      <= 1'b1;
                                wr_addr    <= w_addr;
                                wr_data    <= w_word;
                                tready_out <= 1'b0;
                                r_state    <= WRITE;
                                r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCW'(1);
                                if (w_last_word) begin
                                    // Missing tlast still writes the word, then drains to the next tlast.
                                    if (tlast_in) begin
                                        frame_done <= 1'b1;
                                    end else begin
                                        frame_err <= 1'b1;
                                        r_drain   <= 1'b1;
                                    end
                                end
                            end
                        end else if (tlast_in) begin
                            frame_err  <= 1'b1;
                            r_byte_cnt <= '0;
                            r_word_cnt <= '0;
                        end else begin
                            r_shift    <= {r_shift[DATA_WIDTH-17:0], tdata_in};
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end
                end
                WRITE: begin
                    tready_out <= 1'b1;
                    r_drain    <= 1'b0;
                    r_state    <= r_drain ? DRAIN : RECV;
                end
                DRAIN: begin
                    if (w_accept && tlast_in) begin
                        r_state    <= RECV;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= RECV;
                    tready_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller: write log vs hand-computed expected writes per scenario.
`timescale 1ns/1ps
module tb_input_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [7:0]  wr_addr;
  logic [79:0] wr_data;
  logic        wr_en;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  // log / expected entry = {addr[7:0], data[79:0], done, err}
  logic [89:0] log_q[$];
  logic [89:0] exp_q[$];
  int err_only = 0;
  int rdy_bad = 0;
  int flag_bad = 0;

  input_controller #(
    .ADDR_WIDTH(8), .DATA_WIDTH(80), .NUM_WORDS(4), .ADDR_STEP(4)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .tdata_in(tdata), .tvalid_in(tvalid), .tlast_in(tlast),
    .tready_out(tready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .frame_done(frame_done), .frame_err(frame_err), .o_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) log_q.push_back({wr_addr, wr_data, frame_done, frame_err});
      if (frame_err && !wr_en) err_only++;
      if (tready === wr_en) rdy_bad++;
      if ((frame_done && frame_err) || (frame_done && !wr_en)) flag_bad++;
    end
  end

  function automatic logic [89:0] ent(input logic [7:0] a, input logic [79:0] d,
                                      input logic dn, input logic er);
    return {a, d, dn, er};
  endfunction

  task automatic push_clean();
    exp_q.push_back(ent(8'h00, 80'h0102030405060708090A, 1'b0, 1'b0));
    exp_q.push_back(ent(8'h04, 80'h0B0C0D0E0F1011121314, 1'b0, 1'b0));
    exp_q.push_back(ent(8'h08, 80'h15161718191A1B1C1D1E, 1'b0, 1'b0));
    exp_q.push_back(ent(8'h0C, 80'h1F202122232425262728, 1'b1, 1'b0));
  endtask

  task automatic clear_log();
    log_q.delete();
    exp_q.delete();
    err_only = 0;
    rdy_bad = 0;
    flag_bad = 0;
  endtask

  // driver tasks (called at a negedge, return at the negedge after the accepting edge)
  task automatic send_byte(input logic [7:0] d, input logic l);
    int waited;
    logic ok;
    waited = 0;
    tdata = d;
    tlast = l;
    tvalid = 1'b1;
    do begin
      ok = tready;
      @(negedge clk);
      waited++;
    end while (!ok && waited < 20);
    tvalid = 1'b0;
    tlast = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL handshake_timeout byte=%02h tready stayed low for %0d cycles, required high", d, waited);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input logic last_on_final,
                            input logic throttle, output int lat_bad);
    logic l;
    lat_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (throttle && $urandom_range(0, 1) == 1) @(negedge clk);
      l = last_on_final && (i == n - 1);
      send_byte(8'(base + i), l);
      if (((i + 1) % 10 == 0) && !(l && ((i + 1) % 40 != 0))) begin
        if (wr_en !== 1'b1 || tready !== 1'b0) lat_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tready !== 1'b1) $display("FAIL reset_tready got=%b exp=1", tready); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== 8'h00) $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== 80'h0) $display("FAIL reset_wr_data got=%h exp=0", wr_data); else n_pass++;
    n_checks++; if ({frame_done, frame_err} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {frame_done, frame_err}); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_frame();
    int lat;
    clear_log();
    push_clean();
    send_frame(8'h01, 40, 1'b1, 1'b0, lat);
    repeat (2) @(negedge clk);
    n_checks++; if (lat !== 0) $display("FAIL clean_latency bad_writes=%0d exp=0", lat); else n_pass++;
    n_checks++; if (log_q.size() !== exp_q.size()) $display("FAIL clean_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL clean_write%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 90'h0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_only + rdy_bad + flag_bad !== 0) $display("FAIL clean_flags err=%0d rdy=%0d flag=%0d exp all 0", err_only, rdy_bad, flag_bad); else n_pass++;
  endtask

  task automatic test_throttled();
    int lat;
    clear_log();
    push_clean();
    send_frame(8'h01, 40, 1'b1, 1'b1, lat);
    repeat (2) @(negedge clk);
    n_checks++; if (lat !== 0) $display("FAIL throttle_latency bad_writes=%0d exp=0", lat); else n_pass++;
    n_checks++; if (log_q.size() !== exp_q.size()) $display("FAIL throttle_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL throttle_write%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 90'h0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_only + rdy_bad + flag_bad !== 0) $display("FAIL throttle_flags err=%0d rdy=%0d flag=%0d exp all 0", err_only, rdy_bad, flag_bad); else n_pass++;
  endtask

  task automatic test_early_tlast();
    int lat;
    clear_log();
    exp_q.push_back(ent(8'h00, 80'hA0A1A2A3A4A5A6A7A8A9, 1'b0, 1'b0));
    push_clean();
    send_frame(8'hA0, 15, 1'b1, 1'b0, lat);
    n_checks++; if ({frame_err, wr_en} !== 2'b10) $display("FAIL early_err_pulse got err,wr_en=%b exp=10", {frame_err, wr_en}); else n_pass++;
    send_frame(8'h01, 40, 1'b1, 1'b0, lat);
    repeat (2) @(negedge clk);
    n_checks++; if (log_q.size() !== exp_q.size()) $display("FAIL early_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL early_write%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 90'h0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_only !== 1) $display("FAIL early_err_count got=%0d exp=1", err_only); else n_pass++;
    // tlast on the final byte of word 1: no write of that word
    clear_log();
    exp_q.push_back(ent(8'h00, 80'hB0B1B2B3B4B5B6B7B8B9, 1'b0, 1'b0));
    send_frame(8'hB0, 20, 1'b1, 1'b0, lat);
    n_checks++; if ({frame_err, wr_en} !== 2'b10) $display("FAIL boundary_err_pulse got err,wr_en=%b exp=10", {frame_err, wr_en}); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (log_q.size() !== 1 || log_q[0] !== exp_q[0]) $display("FAIL boundary_write count=%0d exp=1 first_exp=%h", log_q.size(), exp_q[0]); else n_pass++;
    n_checks++; if (lat !== 0) $display("FAIL boundary_latency bad_writes=%0d exp=0", lat); else n_pass++;
  endtask

  task automatic test_missing_tlast();
    int lat;
    clear_log();
    exp_q.push_back(ent(8'h00, 80'h4142434445464748494A, 1'b0, 1'b0));
    exp_q.push_back(ent(8'h04, 80'h4B4C4D4E4F5051525354, 1'b0, 1'b0));
    exp_q.push_back(ent(8'h08, 80'h55565758595A5B5C5D5E, 1'b0, 1'b0));
    exp_q.push_back(ent(8'h0C, 80'h5F606162636465666768, 1'b0, 1'b1));
    push_clean();
    send_frame(8'h41, 40, 1'b0, 1'b0, lat);
    n_checks++; if ({frame_done, frame_err} !== 2'b01) $display("FAIL missing_flags got done,err=%b exp=01", {frame_done, frame_err}); else n_pass++;
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL missing_state got=%0d exp=1", dbg_state); else n_pass++;
    n_checks++; if (lat !== 0) $display("FAIL missing_latency bad_writes=%0d exp=0", lat); else n_pass++;
    send_frame(8'hE1, 3, 1'b1, 1'b0, lat);
    send_frame(8'h01, 40, 1'b1, 1'b0, lat);
    repeat (2) @(negedge clk);
    n_checks++; if (log_q.size() !== exp_q.size()) $display("FAIL missing_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL missing_write%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 90'h0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_only + rdy_bad + flag_bad !== 0) $display("FAIL missing_side err=%0d rdy=%0d flag=%0d exp all 0", err_only, rdy_bad, flag_bad); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    clear_log();
    send_frame(8'h01, 23, 1'b0, 1'b0, lat);
    rst_n = 1'b0;
    #1;
    n_checks++; if (wr_addr !== 8'h00 || wr_data !== 80'h0) $display("FAIL midreset_data got addr=%h data=%h exp 0/0", wr_addr, wr_data); else n_pass++;
    n_checks++; if ({tready, wr_en, frame_done, frame_err} !== 4'b1000) $display("FAIL midreset_ctrl got=%b exp=1000", {tready, wr_en, frame_done, frame_err}); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    push_clean();
    send_frame(8'h01, 40, 1'b1, 1'b0, lat);
    repeat (2) @(negedge clk);
    n_checks++; if (log_q.size() !== exp_q.size()) $display("FAIL midreset_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL midreset_write%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 90'h0, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    clear_log();
    push_clean();
    push_clean();
    send_frame(8'h01, 40, 1'b1, 1'b0, lat1);
    send_frame(8'h01, 40, 1'b1, 1'b0, lat2);
    repeat (2) @(negedge clk);
    n_checks++; if (lat1 + lat2 !== 0) $display("FAIL b2b_latency bad_writes=%0d exp=0", lat1 + lat2); else n_pass++;
    n_checks++; if (log_q.size() !== exp_q.size()) $display("FAIL b2b_count got=%0d exp=%0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL b2b_write%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 90'h0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (err_only + rdy_bad + flag_bad !== 0) $display("FAIL b2b_flags err=%0d rdy=%0d flag=%0d exp all 0", err_only, rdy_bad, flag_bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_throttled();
    test_early_tlast();
    test_missing_tlast();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
